// File: rtl/tec8_timing_pkg.sv
// Shared types and helpers for the TEC-8 beat/phase timing generator.
package tec8_timing_pkg;

    // Phase inside a machine beat; each phase lasts one clk cycle.
    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } phase_e;

    // Machine beat, one-hot so it maps straight onto w1/w2/w3.
    typedef enum logic [2:0] {
        W1 = 3'b001,
        W2 = 3'b010,
        W3 = 3'b100
    } beat_e;

    // Beat that follows the current one at the end of T4.
    // W2 gives short priority over long; W3 always returns to W1;
    // long has no meaning in W1.
    function automatic beat_e next_beat(input beat_e cur, input logic short_req,
                                        input logic long_req);
        beat_e nb;
        nb = W1;
        case (cur)
            W1:      nb = short_req ? W1 : W2;
            W2:      nb = short_req ? W1 : (long_req ? W3 : W1);
            default: nb = W1;
        endcase
        return nb;
    endfunction

    // One-hot phase strobe pattern {t4,t3,t2,t1} for a given phase.
    function automatic logic [3:0] phase_strobe(input phase_e p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/tec8_qd_sync.sv
// Synchroniser for the asynchronous QD push-button plus a one-cycle
// rising-edge pulse taken from the last synchroniser stage.
module tec8_qd_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic qd_async,
    output logic qd_rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Shift the raw button level through the synchroniser chain and keep
    // one cycle of history of the last stage for edge detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], qd_async};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign qd_rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/tec8_timing_gen.sv
// Beat/phase timing generator for the hardwired controller: produces the
// one-hot beat w1..w3 and the registered phase strobes t1..t4.
module tec8_timing_gen
    import tec8_timing_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic qd,
    input  logic short,
    input  logic long,
    input  logic stop,
    output logic w1,
    output logic w2,
    output logic w3,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic t4,
    output logic running,
    output logic beat_end
);

    logic       qd_rise;
    phase_e     phase_reg, phase_next;
    beat_e      beat_reg, beat_next;
    logic       running_reg, running_next;
    logic [3:0] t_reg, t_next;

    tec8_qd_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_qd_sync (
        .clk      (clk),
        .clr      (clr),
        .qd_async (qd),
        .qd_rise  (qd_rise)
    );

    // State register: phase, beat, run flag and the strobe flops.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            phase_reg   <= T1;
            beat_reg    <= W1;
            running_reg <= 1'b0;
            t_reg       <= 4'b0000;
        end else begin
            phase_reg   <= phase_next;
            beat_reg    <= beat_next;
            running_reg <= running_next;
            t_reg       <= t_next;
        end
    end

    // Next state: advance phases while running, change beat at the end of
    // T4 (even when stopping, so the held beat is the one to resume), and
    // accept a start event only while idle. The strobes are precomputed
    // from the next state so t1..t4 come straight from flops.
    always_comb begin
        phase_next   = phase_reg;
        beat_next    = beat_reg;
        running_next = running_reg;
        if (running_reg) begin
            if (phase_reg == T4) begin
                beat_next  = next_beat(beat_reg, short, long);
                phase_next = T1;
                if (stop) begin
                    running_next = 1'b0;
                end
            end else begin
                phase_next = phase_e'(phase_reg + 2'd1);
            end
        end else if (qd_rise) begin
            running_next = 1'b1;
            phase_next   = T1;
        end
        t_next = running_next ? phase_strobe(phase_next) : 4'b0000;
    end

    // Outputs: beat lines, strobes and the end-of-beat flag.
    always_comb begin
        {w3, w2, w1}     = beat_reg;
        {t4, t3, t2, t1} = t_reg;
        running          = running_reg;
        beat_end         = running_reg & (phase_reg == T4);
    end

    // The beat register must always hold exactly one beat.
    assert property (@(posedge clk) disable iff (!clr) $onehot(beat_reg));

    // Strobes are one-hot while running and silent while halted.
    assert property (@(posedge clk) disable iff (!clr)
        running_reg ? $onehot(t_reg) : (t_reg == 4'b0000));

endmodule

// File: tb/tb_tec8_timing_gen.sv
// Scoreboard bench for tec8_timing_gen: each scenario pushes the expected
// per-cycle outputs plus the controller inputs to apply in that cycle, then
// pops one entry per falling edge and compares.
module tb_tec8_timing_gen;

    logic clk, clr, qd, short, long, stop;
    logic w1, w2, w3, t1, t2, t3, t4, running, beat_end;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [2:0] w;   // {w3,w2,w1}
        logic [3:0] t;   // {t4,t3,t2,t1}
        logic       run;
        logic       s;   // short to drive in this cycle
        logic       l;   // long
        logic       p;   // stop
        logic       q;   // qd
    } exp_t;

    exp_t exp_q[$];

    localparam logic [2:0] BW1 = 3'b001;
    localparam logic [2:0] BW2 = 3'b010;
    localparam logic [2:0] BW3 = 3'b100;

    tec8_timing_gen #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .qd       (qd),
        .short    (short),
        .long     (long),
        .stop     (stop),
        .w1       (w1),
        .w2       (w2),
        .w3       (w3),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .t4       (t4),
        .running  (running),
        .beat_end (beat_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_cyc(input logic [2:0] w, input logic [3:0] t, input logic run,
                            input logic s, input logic l, input logic p, input logic q);
        exp_t e;
        e = '{w: w, t: t, run: run, s: s, l: l, p: p, q: q};
        exp_q.push_back(e);
    endtask

    // Four running phases of one beat; controls are applied during T4.
    task automatic push_beat(input logic [2:0] w, input logic s, input logic l,
                             input logic p);
        push_cyc(w, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(w, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(w, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(w, 4'b1000, 1'b1, s,    l,    p,    1'b0);
    endtask

    // One-cycle qd pulse from idle; t1 appears three edges later.
    task automatic push_start(input logic [2:0] w);
        push_cyc(w, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_cyc(w, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(w, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [8:0] obs, req;
        exp_t e;
        clr = 1'b0; qd = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
        req = {BW1, 4'b0000, 1'b0, 1'b0};
        tests_run++;
        if (obs !== req) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b need %b", obs, req);
        end
        clr = 1'b1;
        for (int i = 0; i < 20; i++) push_cyc(BW1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
            req = {e.w, e.t, e.run, e.run & e.t[3]};
            tests_run++;
            if (obs !== req) begin
                tests_failed++;
                $display("FAIL reset_idle: got %b need %b", obs, req);
            end
            short = e.s; long = e.l; stop = e.p; qd = e.q;
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_run();
        logic [8:0] obs, req;
        exp_t e;
        push_start(BW1);
        push_beat(BW1, 1'b0, 1'b0, 1'b0);
        push_beat(BW2, 1'b0, 1'b0, 1'b0);
        push_beat(BW1, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
            req = {e.w, e.t, e.run, e.run & e.t[3]};
            tests_run++;
            if (obs !== req) begin
                tests_failed++;
                $display("FAIL basic_run: got %b need %b", obs, req);
            end
            short = e.s; long = e.l; stop = e.p; qd = e.q;
        end
        $display("[TB] test_basic_run done");
    endtask

    task automatic test_long();
        logic [8:0] obs, req;
        exp_t e;
        push_beat(BW2, 1'b0, 1'b1, 1'b0);   // long in W2 -> W3
        push_beat(BW3, 1'b1, 1'b1, 1'b0);   // W3 ignores both -> W1
        push_beat(BW1, 1'b0, 1'b1, 1'b0);   // long ignored in W1 -> W2
        push_beat(BW2, 1'b0, 1'b0, 1'b0);   // plain W2 -> W1
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
            req = {e.w, e.t, e.run, e.run & e.t[3]};
            tests_run++;
            if (obs !== req) begin
                tests_failed++;
                $display("FAIL long: got %b need %b", obs, req);
            end
            short = e.s; long = e.l; stop = e.p; qd = e.q;
        end
        $display("[TB] test_long done");
    endtask

    task automatic test_short();
        logic [8:0] obs, req;
        exp_t e;
        push_beat(BW1, 1'b1, 1'b0, 1'b0);   // short in W1 -> W1
        push_beat(BW1, 1'b0, 1'b0, 1'b0);   // -> W2
        push_beat(BW2, 1'b1, 1'b1, 1'b0);   // short beats long -> W1
        push_beat(BW1, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
            req = {e.w, e.t, e.run, e.run & e.t[3]};
            tests_run++;
            if (obs !== req) begin
                tests_failed++;
                $display("FAIL short: got %b need %b", obs, req);
            end
            short = e.s; long = e.l; stop = e.p; qd = e.q;
        end
        $display("[TB] test_short done");
    endtask

    task automatic test_stop();
        logic [8:0] obs, req;
        exp_t e;
        push_beat(BW2, 1'b0, 1'b0, 1'b0);   // -> W1
        push_cyc(BW1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // stop outside T4: no effect
        push_cyc(BW1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(BW1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(BW1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // stop at W1 T4
        for (int i = 0; i < 50; i++) push_cyc(BW2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_start(BW2);
        push_cyc(BW2, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(BW2, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // qd while running
        push_cyc(BW2, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_cyc(BW2, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_beat(BW1, 1'b0, 1'b0, 1'b0);
        push_beat(BW2, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
            req = {e.w, e.t, e.run, e.run & e.t[3]};
            tests_run++;
            if (obs !== req) begin
                tests_failed++;
                $display("FAIL stop: got %b need %b", obs, req);
            end
            short = e.s; long = e.l; stop = e.p; qd = e.q;
        end
        $display("[TB] test_stop done");
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs, req;
        exp_t e;
        push_beat(BW1, 1'b0, 1'b0, 1'b0);
        push_cyc(BW2, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
            req = {e.w, e.t, e.run, e.run & e.t[3]};
            tests_run++;
            if (obs !== req) begin
                tests_failed++;
                $display("FAIL reset_mid_pre: got %b need %b", obs, req);
            end
            short = e.s; long = e.l; stop = e.p; qd = e.q;
        end
        @(negedge clk);
        obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
        req = {BW2, 4'b0010, 1'b1, 1'b0};
        tests_run++;
        if (obs !== req) begin
            tests_failed++;
            $display("FAIL reset_mid_w2t2: got %b need %b", obs, req);
        end
        clr = 1'b0;
        #1;
        obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
        req = {BW1, 4'b0000, 1'b0, 1'b0};
        tests_run++;
        if (obs !== req) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %b need %b", obs, req);
        end
        @(negedge clk);
        clr = 1'b1;
        push_start(BW1);
        push_beat(BW1, 1'b0, 1'b0, 1'b0);
        push_cyc(BW2, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {w3, w2, w1, t4, t3, t2, t1, running, beat_end};
            req = {e.w, e.t, e.run, e.run & e.t[3]};
            tests_run++;
            if (obs !== req) begin
                tests_failed++;
                $display("FAIL reset_mid_restart: got %b need %b", obs, req);
            end
            short = e.s; long = e.l; stop = e.p; qd = e.q;
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_long();
        test_short();
        test_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
